// File: rtl/ascon_pack.sv
// ascon_pack: shared types for the Ascon datapath
package ascon_pack;
  typedef logic [63:0] u64_t;
endpackage

// File: rtl/ascon_in_fifo.sv
// ascon_in_fifo: packs 32-bit half-words into 64-bit entries of a FWFT FIFO
module ascon_in_fifo
  import ascon_pack::*;
#(
  parameter int Depth = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [31:0]                wdata_i,
  input  logic                       pop_i,
  output u64_t                       rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       half_o,
  output logic                       ovf_o
);
  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);
  u64_t          mem [Depth];
  logic [PW-1:0] wptr, rptr;
  logic [31:0]   hold;
  logic          accept, push, pop;
  // a full FIFO still takes a second half-word when the same cycle frees a slot
  always_comb begin
    accept = wr_en_i & ~(half_o & full_o & ~pop_i);
    push   = accept & half_o;
    pop    = pop_i & ~empty_o;
  end
  assign empty_o = count_o == '0;
  assign full_o  = count_o == CW'(Depth);
  assign rdata_o = mem[rptr];
  // storage carries no reset; validity lives in the pointers and count
  always_ff @(posedge clk)
    if (push & ~flush_i & ~rst) mem[wptr] <= {hold, wdata_i};
  // pointers, occupancy, packing register and sticky overflow
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
      hold    <= '0;
      half_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      wptr    <= push ? wptr + 1'b1 : wptr;
      rptr    <= pop ? rptr + 1'b1 : rptr;
      count_o <= count_o + CW'(push) - CW'(pop);
      hold    <= accept & ~half_o ? wdata_i : hold;
      half_o  <= accept ? ~half_o : half_o;
      ovf_o   <= ovf_o | (wr_en_i & ~accept);
    end
  end
endmodule

// File: tb/tb_ascon_in_fifo.sv
// tb_ascon_in_fifo: randomized and directed checks against a queue model
module tb_ascon_in_fifo;
  localparam int D = 8;
  logic        clk = 0, rst = 0, flush = 0, wr = 0, pop = 0;
  logic [31:0] wdata = 0;
  logic [63:0] rdata;
  logic        empty, full, half, ovf;
  logic [3:0]  count;
  int          errors = 0, checks = 0;
  logic [63:0] q[$];
  logic [31:0] m_hold;
  bit          m_half, m_ovf;

  ascon_in_fifo #(.Depth(D)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .wr_en_i(wr), .wdata_i(wdata),
    .pop_i(pop), .rdata_o(rdata), .empty_o(empty), .full_o(full),
    .count_o(count), .half_o(half), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit f, input bit w, input logic [31:0] d, input bit p);
    bit acc;
    if (r || f) begin
      q.delete();
      m_half = 0;
      m_ovf  = 0;
      m_hold = 0;
      return;
    end
    acc = w && !(m_half && q.size() == D && !p);
    if (p && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      if (m_half) q.push_back({m_hold, d});
      else m_hold = d;
      m_half = !m_half;
    end else if (w) m_ovf = 1;
  endtask

  task automatic step(input bit r, input bit f, input bit w, input logic [31:0] d, input bit p);
    @(negedge clk);
    rst = r; flush = f; wr = w; wdata = d; pop = p;
    model(r, f, w, d, p);
    @(posedge clk);
    #1;
    rst = 0; flush = 0; wr = 0; pop = 0;
    check("count", 64'(count), 64'(q.size()));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("full", 64'(full), 64'(q.size() == D));
    check("half", 64'(half), 64'(m_half));
    check("ovf", 64'(ovf), 64'(m_ovf));
    if (q.size() > 0) check("rdata", rdata, q[0]);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h01234567, 0);
    check("req31_half1", 64'(half), 64'd1);
    step(0, 0, 1, 32'h89ABCDEF, 0);
    check("req31_half0", 64'(half), 64'd0);
    check("req31_data", rdata, 64'h0123456789ABCDEF);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("pop_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 32'h1000 + i, 0);
    check("req32_full", 64'(full), 64'd1);
    check("req32_cnt", 64'(count), 64'd8);
    step(0, 0, 1, 32'hAAAA0011, 0);
    step(0, 0, 1, 32'hBBBB0012, 0);
    check("req32_ovf", 64'(ovf), 64'd1);
    check("req32_head", rdata, {32'h1000, 32'h1001});
    step(0, 0, 1, 32'hCCCC0013, 1);
    check("req33_cnt", 64'(count), 64'd8);
    check("req33_head", rdata, {32'h1002, 32'h1003});
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    check("req33_drained", 64'(empty), 64'd1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 32'h2000 + 2 * i, 0);
      step(0, 0, 1, 32'h2001 + 2 * i, 0);
      check("req34_wrap", rdata, {32'h2000 + 2 * i, 32'h2001 + 2 * i});
      step(0, 0, 0, 0, 1);
    end
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, $urandom, 0);
    check("req35_pre", 64'(count), 64'd3);
    step(0, 1, 1, 32'hDEADBEEF, 1);
    check("req35_cnt", 64'(count), 64'd0);
    check("req35_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, $urandom, 0);
    step(1, 0, 1, 32'h5555AAAA, 0);
    check("req36_half", 64'(half), 64'd0);
    step(0, 0, 1, 32'hFEEDF00D, 0);
    step(0, 0, 1, 32'hCAFEBABE, 0);
    check("req36_data", rdata, 64'hFEEDF00DCAFEBABE);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
